// File: rtl/cpu_loader_pkg.sv
// cpu_loader_pkg: shared constants for the program loader.
// Opcodes, FSM state encoding and address stride defaults.
package cpu_loader_pkg;

   localparam logic [3:0] OP_LOAD_IMEM = 4'd1;
   localparam logic [3:0] OP_LOAD_DMEM = 4'd2;
   localparam logic [3:0] OP_RUN       = 4'd3;
   localparam logic [3:0] OP_HALT      = 4'd4;

   localparam int IMEM_STRIDE_DEF = 4;
   localparam int DMEM_STRIDE_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ADDR    = 2'd1,
      ST_DATA_LO = 2'd2,
      ST_DATA_HI = 2'd3
   } state_e;

endpackage

// File: rtl/cpu_program_loader.sv
// cpu_program_loader: stream-driven boot sequencer.
// Writes imem/dmem from a header/address/data stream, then runs the cpu.
module cpu_program_loader
   import cpu_loader_pkg::*;
#(
   parameter int ADDR_W      = 64,
   parameter int CNT_W       = 16,
   parameter int IMEM_STRIDE = IMEM_STRIDE_DEF,
   parameter int DMEM_STRIDE = DMEM_STRIDE_DEF
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [31:0]       s_data,
   output logic [ADDR_W-1:0] addr_ext,
   output logic              wen_ext,
   output logic              ren_ext,
   output logic [31:0]       wdata_ext,
   output logic [ADDR_W-1:0] addr_ext_2,
   output logic              wen_ext_2,
   output logic              ren_ext_2,
   output logic [63:0]       wdata_ext_2,
   output logic              cpu_enable,
   output logic              busy,
   output logic              error
);

   state_e              state_q;
   logic                dmem_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         lo_q;
   logic                ready_q;
   logic                en_q;
   logic                err_q;
   logic                wen_q;
   logic [ADDR_W-1:0]   waddr_q;
   logic [31:0]         wdata_q;
   logic                wen2_q;
   logic [ADDR_W-1:0]   waddr2_q;
   logic [63:0]         wdata2_q;

   logic [3:0]          op_d;
   logic                beat_d;
   logic                is_load_d;
   logic                is_run_d;
   logic                is_halt_d;
   logic                last_d;
   logic [CNT_W-1:0]    cnt_dec_d;
   logic [ADDR_W-1:0]   addr_imem_d;
   logic [ADDR_W-1:0]   addr_dmem_d;

   // Header decode and counter/address next values
   always_comb begin
      op_d        = s_data[31:28];
      beat_d      = s_valid & ready_q;
      is_load_d   = (op_d == OP_LOAD_IMEM) |
                    (op_d == OP_LOAD_DMEM);
      is_run_d    = (op_d == OP_RUN);
      is_halt_d   = (op_d == OP_HALT);
      last_d      = (cnt_q == CNT_W'(1));
      cnt_dec_d   = cnt_q - CNT_W'(1);
      addr_imem_d = addr_q + ADDR_W'(IMEM_STRIDE);
      addr_dmem_d = addr_q + ADDR_W'(DMEM_STRIDE);
   end

   // Loader FSM with registered memory-port and status outputs
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= ST_IDLE;
         dmem_q   <= 1'b0;
         cnt_q    <= '0;
         addr_q   <= '0;
         lo_q     <= '0;
         ready_q  <= 1'b0;
         en_q     <= 1'b0;
         err_q    <= 1'b0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         wen2_q   <= 1'b0;
         waddr2_q <= '0;
         wdata2_q <= '0;
      end else begin
         ready_q <= 1'b1;
         wen_q   <= 1'b0;
         wen2_q  <= 1'b0;
         if (beat_d) begin
            unique case (state_q)
               ST_IDLE: begin
                  unique case (1'b1)
                     is_load_d: begin
                        if (en_q) begin
                           err_q <= 1'b1;
                        end else begin
                           dmem_q  <= (op_d == OP_LOAD_DMEM);
                           cnt_q   <= s_data[CNT_W-1:0];
                           state_q <= ST_ADDR;
                        end
                     end
                     is_run_d:  en_q  <= 1'b1;
                     is_halt_d: en_q  <= 1'b0;
                     default:   err_q <= 1'b1;
                  endcase
               end
               ST_ADDR: begin
                  addr_q  <= ADDR_W'(s_data);
                  state_q <= (cnt_q == '0) ? ST_IDLE
                                           : ST_DATA_LO;
               end
               ST_DATA_LO: begin
                  if (dmem_q) begin
                     lo_q    <= s_data;
                     state_q <= ST_DATA_HI;
                  end else begin
                     wen_q   <= 1'b1;
                     waddr_q <= addr_q;
                     wdata_q <= s_data;
                     addr_q  <= addr_imem_d;
                     cnt_q   <= cnt_dec_d;
                     if (last_d) state_q <= ST_IDLE;
                  end
               end
               ST_DATA_HI: begin
                  wen2_q   <= 1'b1;
                  waddr2_q <= addr_q;
                  wdata2_q <= {s_data, lo_q};
                  addr_q   <= addr_dmem_d;
                  cnt_q    <= cnt_dec_d;
                  state_q  <= last_d ? ST_IDLE
                                     : ST_DATA_LO;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign s_ready     = ready_q;
   assign addr_ext    = waddr_q;
   assign wen_ext     = wen_q;
   assign ren_ext     = 1'b0;
   assign wdata_ext   = wdata_q;
   assign addr_ext_2  = waddr2_q;
   assign wen_ext_2   = wen2_q;
   assign ren_ext_2   = 1'b0;
   assign wdata_ext_2 = wdata2_q;
   assign cpu_enable  = en_q;
   assign busy        = (state_q != ST_IDLE);
   assign error       = err_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// tb_cpu_program_loader: directed and randomized bench.
// Captured writes are checked against an arithmetic model.
module tb_cpu_program_loader;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_ready;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic        cpu_enable;
   logic        busy;
   logic        error;

   cpu_program_loader dut (
      .clk(clk), .arst_n(arst_n),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data),
      .addr_ext(addr_ext), .wen_ext(wen_ext),
      .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
      .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
      .cpu_enable(cpu_enable), .busy(busy),
      .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] d;
      int          c;
   } wr_t;

   wr_t imem_got[$];
   wr_t dmem_got[$];
   wr_t imem_exp[$];
   wr_t dmem_exp[$];
   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (wen_ext === 1'b1)
         imem_got.push_back('{addr_ext, {32'd0, wdata_ext}, cyc});
      if (wen_ext_2 === 1'b1)
         dmem_got.push_back('{addr_ext_2, wdata_ext_2, cyc});
   end

   task automatic clear_q();
      imem_got.delete(); dmem_got.delete();
      imem_exp.delete(); dmem_exp.delete();
   endtask

   task automatic apply_reset();
      s_valid = 1'b0;
      arst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      @(posedge clk); #1;
      clear_q();
   endtask

   task automatic send(input logic [31:0] w, input int gap);
      s_data = w; s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0; s_data = $urandom;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Model: a load of n words expects writes at base + i*stride.
   task automatic do_load(input bit dm, input logic [31:0] base,
                          input int n, input int maxgap);
      logic [31:0] lo, hi;
      send({dm ? 4'd2 : 4'd1, 12'd0, 16'(n)}, $urandom_range(maxgap));
      send(base, $urandom_range(maxgap));
      for (int i = 0; i < n; i++) begin
         lo = $urandom;
         send(lo, $urandom_range(maxgap));
         if (dm) begin
            hi = $urandom;
            send(hi, $urandom_range(maxgap));
            dmem_exp.push_back('{64'(base) + 64'(i) * 64'd8,
                                 {hi, lo}, 0});
         end else begin
            imem_exp.push_back('{64'(base) + 64'(i) * 64'd4,
                                 {32'd0, lo}, 0});
         end
      end
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      s_valid = 1'b1; s_data = 32'h1000_0003;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({s_ready, wen_ext, wen_ext_2, ren_ext, ren_ext_2,
           cpu_enable, busy, error} !== 8'd0 ||
          addr_ext !== 64'd0 || wdata_ext !== 32'd0 ||
          addr_ext_2 !== 64'd0 || wdata_ext_2 !== 64'd0) begin
         failures++;
         $display("FAIL reset_outputs: got rdy=%b wen=%b en=%b busy=%b err=%b want all 0",
                  s_ready, wen_ext, cpu_enable, busy, error);
      end
      s_valid = 1'b0;
      arst_n = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_before_edge: got %b want 0", s_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (s_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_edge: got %b want 1", s_ready);
      end
      clear_q();
   endtask

   task automatic test_imem();
      logic [31:0] d [3];
      apply_reset();
      d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;
      send(32'h1000_0003, 0);
      send(32'h0000_0000, 0);
      for (int i = 0; i < 3; i++) send(d[i], 0);
      settle();
      checks++;
      if (imem_got.size() != 3 || dmem_got.size() != 0) begin
         failures++;
         $display("FAIL imem_count: got %0d/%0d want 3/0",
                  imem_got.size(), dmem_got.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_got[i].a !== 64'(4 * i) ||
                imem_got[i].d !== {32'd0, d[i]}) begin
               failures++;
               $display("FAIL imem_write%0d: got a=%h d=%h want a=%h d=%h",
                        i, imem_got[i].a, imem_got[i].d, 4 * i, d[i]);
            end
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL imem_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_dmem();
      apply_reset();
      send(32'h2000_0002, 0);
      send(32'h0000_0100, 0);
      send(32'h1, 0); send(32'h2, 0);
      send(32'h3, 0); send(32'h4, 0);
      settle();
      checks++;
      if (dmem_got.size() != 2 || imem_got.size() != 0) begin
         failures++;
         $display("FAIL dmem_count: got %0d/%0d want 2/0",
                  dmem_got.size(), imem_got.size());
      end else begin
         checks++;
         if (dmem_got[0].a !== 64'h100 ||
             dmem_got[0].d !== 64'h0000_0002_0000_0001) begin
            failures++;
            $display("FAIL dmem_write0: got a=%h d=%h want a=100 d=0000000200000001",
                     dmem_got[0].a, dmem_got[0].d);
         end
         checks++;
         if (dmem_got[1].a !== 64'h108 ||
             dmem_got[1].d !== 64'h0000_0004_0000_0003) begin
            failures++;
            $display("FAIL dmem_write1: got a=%h d=%h want a=108 d=0000000400000003",
                     dmem_got[1].a, dmem_got[1].d);
         end
      end
   endtask

   task automatic test_run_halt();
      logic [31:0] w [4];
      logic        want [4];
      apply_reset();
      w[0] = 32'h3000_0000; want[0] = 1'b1;
      w[1] = 32'h3000_0000; want[1] = 1'b1;
      w[2] = 32'h4000_0000; want[2] = 1'b0;
      w[3] = 32'h4000_0000; want[3] = 1'b0;
      checks++;
      if (cpu_enable !== 1'b0) begin
         failures++;
         $display("FAIL run_pre: got %b want 0", cpu_enable);
      end
      for (int i = 0; i < 4; i++) begin
         send(w[i], 0);
         checks++;
         if (cpu_enable !== want[i]) begin
            failures++;
            $display("FAIL run_halt%0d: got %b want %b",
                     i, cpu_enable, want[i]);
         end
      end
      checks++;
      if (error !== 1'b0) begin
         failures++;
         $display("FAIL run_halt_err: got %b want 0", error);
      end
   endtask

   task automatic test_load_while_running();
      apply_reset();
      send(32'h3000_0000, 0);
      send(32'h1000_0001, 0);
      checks++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL load_running: got err=%b busy=%b want 1/0",
                  error, busy);
      end
      send(32'h4000_0000, 0);
      settle();
      checks++;
      if (cpu_enable !== 1'b0 || imem_got.size() != 0) begin
         failures++;
         $display("FAIL load_running_next_hdr: got en=%b writes=%0d want 0/0",
                  cpu_enable, imem_got.size());
      end
   endtask

   task automatic test_unknown_op();
      logic [31:0] w [2];
      w[0] = 32'h7000_0000;
      w[1] = 32'h0000_0005;
      for (int i = 0; i < 2; i++) begin
         apply_reset();
         checks++;
         if (error !== 1'b0) begin
            failures++;
            $display("FAIL unk_pre%0d: got %b want 0", i, error);
         end
         send(w[i], 0);
         checks++;
         if (error !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL unk_op%0d: got err=%b busy=%b want 1/0",
                     i, error, busy);
         end
      end
      send(32'h3000_0000, 0);
      send(32'h4000_0000, 2);
      checks++;
      if (error !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky: got %b want 1", error);
      end
   endtask

   task automatic test_zero_count();
      apply_reset();
      send(32'h1000_0000, 0);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL zero_hdr_busy: got %b want 1", busy);
      end
      send(32'h0000_0040, 0);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL zero_addr_busy: got %b want 0", busy);
      end
      send(32'h3000_0000, 0);
      settle();
      checks++;
      if (imem_got.size() != 0 || dmem_got.size() != 0 ||
          cpu_enable !== 1'b1) begin
         failures++;
         $display("FAIL zero_count: got writes=%0d/%0d en=%b want 0/0/1",
                  imem_got.size(), dmem_got.size(), cpu_enable);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      do_load(1'b0, 32'h0000_1000, 4, 0);
      settle();
      checks++;
      if (imem_got.size() != 4) begin
         failures++;
         $display("FAIL b2b_count: got %0d want 4", imem_got.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (imem_got[i].c !== imem_got[0].c + i ||
                imem_got[i].a !== imem_exp[i].a) begin
               failures++;
               $display("FAIL b2b_pulse%0d: got cyc=%0d a=%h want cyc=%0d a=%h",
                        i, imem_got[i].c, imem_got[i].a,
                        imem_got[0].c + i, imem_exp[i].a);
            end
         end
      end
   endtask

   task automatic test_reset_mid_load();
      apply_reset();
      send(32'h1000_0004, 1);
      send(32'h0000_0200, 2);
      send(32'hDEAD_0001, 3);
      send(32'hDEAD_0002, 0);
      arst_n = 1'b0;
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({s_ready, wen_ext, wen_ext_2, cpu_enable,
              busy, error} !== 6'd0 || addr_ext !== 64'd0 ||
             wdata_ext !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_out%0d: got rdy=%b wen=%b busy=%b a=%h want 0",
                     i, s_ready, wen_ext, busy, addr_ext);
         end
      end
      s_valid = 1'b0;
      checks++;
      if (imem_got.size() != 1) begin
         failures++;
         $display("FAIL mid_reset_pulses: got %0d want 1",
                  imem_got.size());
      end else begin
         checks++;
         if (imem_got[0].a !== 64'h200 ||
             imem_got[0].d !== 64'hDEAD_0001) begin
            failures++;
            $display("FAIL mid_reset_write: got a=%h d=%h want 200/dead0001",
                     imem_got[0].a, imem_got[0].d);
         end
      end
      arst_n = 1'b1;
      @(posedge clk); #1;
      imem_got.delete();
      send(32'h3000_0000, 0);
      settle();
      checks++;
      if (busy !== 1'b0 || cpu_enable !== 1'b1 ||
          imem_got.size() != 0) begin
         failures++;
         $display("FAIL mid_reset_idle: got busy=%b en=%b writes=%0d want 0/1/0",
                  busy, cpu_enable, imem_got.size());
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int k = 0; k < 10; k++)
         do_load(1'($urandom_range(1)), $urandom,
                 $urandom_range(5, 1), 2);
      settle();
      checks++;
      if (imem_got.size() != imem_exp.size() ||
          dmem_got.size() != dmem_exp.size()) begin
         failures++;
         $display("FAIL rand_count: got %0d/%0d want %0d/%0d",
                  imem_got.size(), dmem_got.size(),
                  imem_exp.size(), dmem_exp.size());
      end else begin
         foreach (imem_exp[i]) begin
            checks++;
            if (imem_got[i].a !== imem_exp[i].a ||
                imem_got[i].d !== imem_exp[i].d) begin
               failures++;
               $display("FAIL rand_imem%0d: got a=%h d=%h want a=%h d=%h",
                        i, imem_got[i].a, imem_got[i].d,
                        imem_exp[i].a, imem_exp[i].d);
            end
         end
         foreach (dmem_exp[i]) begin
            checks++;
            if (dmem_got[i].a !== dmem_exp[i].a ||
                dmem_got[i].d !== dmem_exp[i].d) begin
               failures++;
               $display("FAIL rand_dmem%0d: got a=%h d=%h want a=%h d=%h",
                        i, dmem_got[i].a, dmem_got[i].d,
                        dmem_exp[i].a, dmem_exp[i].d);
            end
         end
      end
      checks++;
      if (busy !== 1'b0 || error !== 1'b0) begin
         failures++;
         $display("FAIL rand_status: got busy=%b err=%b want 0/0",
                  busy, error);
      end
   endtask

   initial begin
      test_reset();
      test_imem();
      test_dmem();
      test_run_halt();
      test_load_while_running();
      test_unknown_op();
      test_zero_count();
      test_back_to_back();
      test_reset_mid_load();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
